// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: MM:SS elapsed-time counter kept as four BCD digits.
// It counts tick pulses from the upstream tick timer. A start_stop level input
// is edge-detected and toggles run/pause. clear returns the count to 00:00 and
// the FSM to IDLE.
//
// Inputs are sampled on the rising edge of clk. The tick pulse has no
// handshake: each cycle in which tick is high is one tick. There is no
// ready/back-pressure in either direction.
module stopwatch_bcd #(
   parameter int TICKS_PER_SEC = 1,
   parameter int PW            = $clog2(TICKS_PER_SEC + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          tick,
   input  logic          start_stop,
   input  logic          clear,
   output logic [3:0]    sec_ones,
   output logic [3:0]    sec_tens,
   output logic [3:0]    min_ones,
   output logic [3:0]    min_tens,
   output logic          running,
   output logic          wrap,
   output logic [1:0]    state_dbg,
   output logic [PW-1:0] presc_dbg
);

   // FSM encoding. The spare code 2'b11 falls back to IDLE.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;

   localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

   localparam logic [3:0] MAX_NINE = 4'd9;
   localparam logic [3:0] MAX_FIVE = 4'd5;

   logic [1:0]    state;
   logic [1:0]    state_n;
   logic          ss_d;
   logic          ss_edge;
   logic          cnt_en;
   logic [PW-1:0] presc;
   logic [PW-1:0] presc_n;
   logic          presc_last;
   logic          sec_adv;

   logic [3:0] so_n;
   logic [3:0] st_n;
   logic [3:0] mo_n;
   logic [3:0] mt_n;
   logic       c_so;
   logic       c_st;
   logic       c_mo;
   logic       c_mt;
   logic       wrap_n;

   // Next value of one BCD digit.
   // An out-of-range digit is forced back to 0. At max, an advance wraps
   // the digit to 0.
   function automatic logic [3:0] digit_next(input logic [3:0] d,
                                             input logic [3:0] max,
                                             input logic       adv);
      logic [3:0] r;
      if (d > max) begin
         r = 4'd0;
      end else if (adv) begin
         r = (d == max) ? 4'd0 : d + 4'd1;
      end else begin
         r = d;
      end
      return r;
   endfunction

   // Carry out of one digit: it is advancing and currently sits at its max.
   function automatic logic digit_carry(input logic [3:0] d,
                                        input logic [3:0] max,
                                        input logic       adv);
      return adv && (d == max);
   endfunction

   assign ss_edge   = start_stop & ~ss_d;
   assign running   = (state == ST_RUN);
   assign state_dbg = state;
   assign presc_dbg = presc;

   // Count only on ticks seen while the registered state is RUN.
   // A tick in the same cycle as the starting edge is therefore ignored.
   // A tick in the same cycle as the pausing edge is still counted.
   assign cnt_en = tick & (state == ST_RUN) & ~clear;

   // Run/pause FSM next state. clear overrides any start_stop edge.
   always_comb begin
      state_n = state;
      if (clear) begin
         state_n = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (ss_edge) state_n = ST_RUN;
            ST_RUN:   if (ss_edge) state_n = ST_PAUSE;
            ST_PAUSE: if (ss_edge) state_n = ST_RUN;
            default:  state_n = ST_IDLE;
         endcase
      end
   end

   // Prescaler: divides ticks down to one seconds advance.
   always_comb begin
      presc_last = (presc >= PRESC_MAX);
      presc_n    = presc;
      sec_adv    = 1'b0;
      if (cnt_en) begin
         if (presc_last) begin
            presc_n = '0;
            sec_adv = 1'b1;
         end else begin
            presc_n = presc + PW'(1);
         end
      end
   end

   // Ripple-carry BCD chain. All four digits settle in a single cycle.
   always_comb begin
      so_n   = digit_next(sec_ones, MAX_NINE, sec_adv);
      c_so   = digit_carry(sec_ones, MAX_NINE, sec_adv);
      st_n   = digit_next(sec_tens, MAX_FIVE, c_so);
      c_st   = digit_carry(sec_tens, MAX_FIVE, c_so);
      mo_n   = digit_next(min_ones, MAX_NINE, c_st);
      c_mo   = digit_carry(min_ones, MAX_NINE, c_st);
      mt_n   = digit_next(min_tens, MAX_FIVE, c_mo);
      c_mt   = digit_carry(min_tens, MAX_FIVE, c_mo);
      wrap_n = c_mt;
   end

   // State, edge-detect history, prescaler and digit registers.
   // reset has the highest priority, then clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         ss_d     <= 1'b0;
         presc    <= '0;
         sec_ones <= 4'd0;
         sec_tens <= 4'd0;
         min_ones <= 4'd0;
         min_tens <= 4'd0;
         wrap     <= 1'b0;
      end else begin
         ss_d  <= start_stop;
         state <= state_n;
         if (clear) begin
            presc    <= '0;
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
            wrap     <= 1'b0;
         end else begin
            presc    <= presc_n;
            sec_ones <= so_n;
            sec_tens <= st_n;
            min_ones <= mo_n;
            min_tens <= mt_n;
            wrap     <= wrap_n;
         end
      end
   end

endmodule
